aes_modo_cifra: RTL

//  Multi-block AES-128 sequencer wrapping the existing controladorCriptografia core (one instance).

---
 rtl/aes_modo_cifra.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_modo_cifra.sv
// rtl/aes_modo_cifra.sv - multi-block AES-128 ECB/CBC/CTR sequencer around an iterative core
// The core computes one AES round per clock; the wrapper adds stream handshakes and chaining.

module controladorCriptografia (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] chave,
  input  logic [127:0] palavra,
  output logic [127:0] cifra,
  output logic         done
);

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (a^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] p;
    logic [7:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h000000};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte 4*c+r of the state sits at bits 127-8*(4*c+r); the last round skips MixColumns.
  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [15:0][7:0] sb;
    logic [15:0][7:0] sr;
    logic [127:0]     o;
    logic [7:0]       a0, a1, a2, a3;
    o = '0;
    for (int i = 0; i < 16; i++) sb[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        sr[4*c+r] = sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      a0 = sr[4*c];
      a1 = sr[4*c+1];
      a2 = sr[4*c+2];
      a3 = sr[4*c+3];
      if (last) o[127-32*c -: 32] = {a0, a1, a2, a3};
      else o[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    end
    return o ^ k;
  endfunction

  logic [127:0] st_q, st_d, rk_q, rk_d, nk;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   rnd_q, rnd_d;
  logic         run_q, run_d, done_q, done_d;

  always_comb begin
    nk     = key_next(rk_q, rcon_q);
    st_d   = st_q;
    rk_d   = rk_q;
    rcon_d = rcon_q;
    rnd_d  = rnd_q;
    run_d  = run_q;
    done_d = done_q;
    if (start) begin
      st_d   = palavra ^ chave;
      rk_d   = chave;
      rcon_d = 8'h01;
      rnd_d  = 4'd1;
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (run_q) begin
      st_d   = aes_round(st_q, nk, rnd_q == 4'd10);
      rk_d   = nk;
      rcon_d = xt(rcon_q);
      rnd_d  = rnd_q + 4'd1;
      if (rnd_q == 4'd10) begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '0;
      rk_q   <= '0;
      rcon_q <= '0;
      rnd_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      rk_q   <= rk_d;
      rcon_q <= rcon_d;
      rnd_q  <= rnd_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign cifra = st_q;
  assign done  = done_q;

endmodule

module aes_modo_cifra #(
  parameter int NUM_BLOCOS_MAX = 16,
  localparam int CW = $clog2(NUM_BLOCOS_MAX + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  chave,
  input  logic [127:0]  iv,
  input  logic [1:0]    modo,
  input  logic [CW-1:0] num_blocos,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [127:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic          busy,
  output logic          done,
  output logic          erro
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CORE_CLR, S_CORE_GO, S_CORE_WAIT, S_OUT, S_FIN
  } state_t;

  localparam logic [1:0] M_CBC = 2'd1;
  localparam logic [1:0] M_CTR = 2'd2;

  state_t          state_q, state_d;
  logic [1:0]      modo_q, modo_d;
  logic [CW-1:0]   num_q, num_d, cnt_q, cnt_d;
  logic [127:0]    chave_q, chave_d, chain_q, chain_d, blk_q, blk_d;
  logic [127:0]    palavra_q, palavra_d, out_data_q, out_data_d;
  logic            in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic            busy_q, busy_d, done_q, done_d, erro_q, erro_d;
  logic            core_clr_q, core_clr_d, core_start_q, core_start_d;
  logic            core_rst, core_done;
  logic [127:0]    core_cifra;

  // A fresh core reset before every block guarantees a stale done cannot be mistaken for a result.
  assign core_rst = ~rst | core_clr_q;

  controladorCriptografia u_core (
    .clk     (clk),
    .rst     (core_rst),
    .start   (core_start_q),
    .chave   (chave_q),
    .palavra (palavra_q),
    .cifra   (core_cifra),
    .done    (core_done)
  );

  always_comb begin
    state_d    = state_q;
    modo_d     = modo_q;
    num_d      = num_q;
    cnt_d      = cnt_q;
    chave_d    = chave_q;
    chain_d    = chain_q;
    blk_d      = blk_q;
    palavra_d  = palavra_q;
    out_data_d = out_data_q;
    erro_d     = erro_q;
    done_d     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (modo == 2'd3 || num_blocos == '0 || num_blocos > CW'(NUM_BLOCOS_MAX)) begin
            erro_d = 1'b1;
            done_d = 1'b1;
          end else begin
            erro_d  = 1'b0;
            modo_d  = modo;
            num_d   = num_blocos;
            chave_d = chave;
            chain_d = iv;
            cnt_d   = '0;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_valid && in_ready_q) begin
          blk_d   = in_data;
          state_d = S_CORE_CLR;
        end
      end
      S_CORE_CLR: begin
        unique case (modo_q)
          M_CBC:   palavra_d = blk_q ^ chain_q;
          M_CTR:   palavra_d = chain_q;
          default: palavra_d = blk_q;
        endcase
        state_d = S_CORE_GO;
      end
      S_CORE_GO: state_d = S_CORE_WAIT;
      S_CORE_WAIT: begin
        if (core_done) begin
          out_data_d = (modo_q == M_CTR) ? (core_cifra ^ blk_q) : core_cifra;
          state_d    = S_OUT;
        end
      end
      S_OUT: begin
        if (out_valid_q && out_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (modo_q == M_CBC) chain_d = out_data_q;
          else if (modo_q == M_CTR) chain_d = chain_q + 128'd1;
          state_d = (cnt_d == num_q) ? S_FIN : S_LOAD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d   = (state_d == S_LOAD);
    out_valid_d  = (state_d == S_OUT);
    busy_d       = (state_d != S_IDLE) && (state_d != S_FIN);
    done_d       = done_d | (state_d == S_FIN);
    core_clr_d   = (state_d == S_CORE_CLR);
    core_start_d = (state_d == S_CORE_GO);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      modo_q       <= '0;
      num_q        <= '0;
      cnt_q        <= '0;
      chave_q      <= '0;
      chain_q      <= '0;
      blk_q        <= '0;
      palavra_q    <= '0;
      out_data_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      erro_q       <= 1'b0;
      core_clr_q   <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      modo_q       <= modo_d;
      num_q        <= num_d;
      cnt_q        <= cnt_d;
      chave_q      <= chave_d;
      chain_q      <= chain_d;
      blk_q        <= blk_d;
      palavra_q    <= palavra_d;
      out_data_q   <= out_data_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      erro_q       <= erro_d;
      core_clr_q   <= core_clr_d;
      core_start_q <= core_start_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign erro      = erro_q;

endmodule
